// File: rtl/ms_timing_pkg.sv
// Shared timing definitions for the ms-domain blocks (pulse generator and
// measurement timer): counter width and the pulse-generator state encoding.
package ms_timing_pkg;

  localparam int unsigned CNT_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_DELAY = 2'd1,
    PG_PULSE = 2'd2
  } pg_state_t;

endpackage

// File: rtl/ms_pulse_generator_if.sv
// Request/status bundle for ms_pulse_generator.
//   master (control FSM / bench): drives start, stop, delay_ms, width_ms
//                                 (and repeat_en when MS_PULSE_REPEAT_EN is defined)
//   slave  (pulse generator)    : drives pulse_out, busy, done, aborted, remaining_ms
interface ms_pulse_generator_if
  import ms_timing_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] delay_ms;
  logic [CNT_W-1:0] width_ms;
`ifdef MS_PULSE_REPEAT_EN
  logic             repeat_en;
`endif
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] remaining_ms;

  modport master (
`ifdef MS_PULSE_REPEAT_EN
    output repeat_en,
`endif
    output start, stop, delay_ms, width_ms,
    input  pulse_out, busy, done, aborted, remaining_ms
  );

  modport slave (
`ifdef MS_PULSE_REPEAT_EN
    input  repeat_en,
`endif
    input  start, stop, delay_ms, width_ms,
    output pulse_out, busy, done, aborted, remaining_ms
  );

endinterface

// File: rtl/ms_down_counter.sv
// Loadable down-counter, saturating at zero.
//   clk_1khz, reset : clock, async active-high reset
//   clr             : force count to 0 (priority over load)
//   load, load_val  : load a new value
//   en              : decrement by one (held at 0, never wraps)
//   count, zero     : current value and count==0 flag
module ms_down_counter
  import ms_timing_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_1khz,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_1khz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && !zero) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/ms_pulse_generator.sv
// Millisecond timed-pulse generator (1 cycle of clk_1khz = 1 ms).
// After an accepted start, waits delay_ms, then drives pulse_out for width_ms.
//   clk_1khz, reset : clock, async active-high reset
//   bus (slave)     : start/stop/delay_ms/width_ms in;
//                     pulse_out/busy/done/aborted/remaining_ms out (all registered)
// Optional feature: define MS_PULSE_REPEAT_EN to add bus.repeat_en, which makes a
// request with width > 0 repeat its delay+pulse period until stopped.
module ms_pulse_generator
  import ms_timing_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk_1khz,
  input  logic                  reset,
  ms_pulse_generator_if.slave   bus
);

  pg_state_t        state_q, state_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
`ifdef MS_PULSE_REPEAT_EN
  logic             rpt_q, rpt_d;
`endif

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_zero;

  logic             last_c;
  logic             launch_c;
  logic [CNT_W-1:0] launch_delay_c;
  logic [CNT_W-1:0] launch_width_c;
  logic             finish_c;
  logic             abort_c;

  // Phase countdown; its value is the remaining_ms output.
  ms_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_1khz (clk_1khz),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // The phase ends on the edge where the count would reach zero; zero itself
  // is only a guard against a stuck phase.
  assign last_c = cnt_zero || (cnt_count == CNT_W'(1));

  // State register.
  always_ff @(posedge clk_1khz or posedge reset) begin
    if (reset) begin
      state_q   <= PG_IDLE;
      delay_q   <= '0;
      width_q   <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef MS_PULSE_REPEAT_EN
      rpt_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
`ifdef MS_PULSE_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    delay_d        = delay_q;
    width_d        = width_q;
    pulse_d        = pulse_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    aborted_d      = 1'b0;
`ifdef MS_PULSE_REPEAT_EN
    rpt_d          = rpt_q;
`endif
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    cnt_en         = 1'b0;
    cnt_clr        = 1'b0;
    launch_c       = 1'b0;
    launch_delay_c = delay_q;
    launch_width_c = width_q;
    finish_c       = 1'b0;
    abort_c        = 1'b0;

    case (state_q)
      PG_IDLE: begin
        // stop outranks start, so start+stop together is not accepted
        if (bus.start && !bus.stop) begin
          launch_c       = 1'b1;
          launch_delay_c = bus.delay_ms;
          launch_width_c = bus.width_ms;
          delay_d        = bus.delay_ms;
          width_d        = bus.width_ms;
`ifdef MS_PULSE_REPEAT_EN
          rpt_d          = bus.repeat_en;
`endif
        end
      end

      PG_DELAY: begin
        if (bus.stop) begin
          abort_c = 1'b1;
        end else if (last_c) begin
          if (width_q != '0) begin
            state_d      = PG_PULSE;
            cnt_load     = 1'b1;
            cnt_load_val = width_q;
            pulse_d      = 1'b1;
          end else begin
            finish_c = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      PG_PULSE: begin
        if (bus.stop) begin
          abort_c = 1'b1;
        end else if (last_c) begin
`ifdef MS_PULSE_REPEAT_EN
          // Back-to-back period: restart from the latched delay/width.
          if (rpt_q) begin
            launch_c = 1'b1;
            done_d   = 1'b1;
          end else begin
            finish_c = 1'b1;
          end
`else
          finish_c = 1'b1;
`endif
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_d = PG_IDLE;
        cnt_clr = 1'b1;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Enter the first phase of a request; zero-length phases are skipped.
    if (launch_c) begin
      busy_d = 1'b1;
      if (launch_delay_c != '0) begin
        state_d      = PG_DELAY;
        cnt_load     = 1'b1;
        cnt_load_val = launch_delay_c;
        pulse_d      = 1'b0;
      end else if (launch_width_c != '0) begin
        state_d      = PG_PULSE;
        cnt_load     = 1'b1;
        cnt_load_val = launch_width_c;
        pulse_d      = 1'b1;
      end else begin
        state_d = PG_IDLE;
        cnt_clr = 1'b1;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (finish_c) begin
      state_d = PG_IDLE;
      cnt_clr = 1'b1;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    if (abort_c) begin
      state_d   = PG_IDLE;
      cnt_clr   = 1'b1;
      pulse_d   = 1'b0;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  assign bus.pulse_out    = pulse_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.remaining_ms = cnt_count;

endmodule
